cache_refill_seq: RTL and testbench

Line-refill sequencer for the CPU data cache, sitting directly behind the cache stall gate. It consumes the gated `cache_enable` strobe and the cache's tag-compare result, detects read misses, fetches the missing line from memory as a linear burst and writes it into the data array. It then commits the tag. While a refill is in flight it drives `cache_busy_n` low, which the stall gate uses to hold off further non-forced CPU accesses.

---
 rtl/cache_refill_seq_if.sv | 37 +++
 rtl/cache_refill_seq.sv | 111 +++++++++++
 tb/tb_cache_refill_seq.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_refill_seq_if.sv
// Signal bundle between the cache refill sequencer, the CPU-side cache pipeline and memory.
// mem_req is held with a stable mem_addr until mem_ack is sampled high; mem_rvalid has no backpressure.
interface cache_refill_seq_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              cache_enable;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_we;
    logic              lookup_hit;
    logic              cache_busy_n;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              tag_we;
    logic [ADDR_W-1:0] tag_addr;
    logic [1:0]        dbg_state;

    modport master (
        input  cache_enable, cpu_addr, cpu_we, lookup_hit,
        input  mem_ack, mem_rvalid, mem_rdata,
        output cache_busy_n, mem_req, mem_addr,
        output fill_we, fill_addr, fill_data, tag_we, tag_addr, dbg_state
    );

    modport slave (
        output cache_enable, cpu_addr, cpu_we, lookup_hit,
        output mem_ack, mem_rvalid, mem_rdata,
        input  cache_busy_n, mem_req, mem_addr,
        input  fill_we, fill_addr, fill_data, tag_we, tag_addr, dbg_state
    );
endinterface

// File: rtl/cache_refill_seq.sv
// Data-cache line refill sequencer: detects read misses, bursts the line in from memory,
// writes it into the data array and commits the tag. All outputs are registered.
module cache_refill_seq #(
    parameter int ADDR_W    = 30,
    parameter int DATA_W    = 32,
    parameter int LINE_LOG2 = 2
) (
    input  logic               CLK,
    input  logic               RST,
    cache_refill_seq_if.master bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        FILL   = 2'd2,
        COMMIT = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0]    LINE_MASK = ~ADDR_W'((1 << LINE_LOG2) - 1);
    localparam logic [LINE_LOG2-1:0] LAST_WORD = '1;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     line_base_q, line_base_d;
    logic [LINE_LOG2-1:0]  count_q, count_d;
    logic                  busy_n_q, busy_n_d;
    logic                  mem_req_q, mem_req_d;
    logic                  fill_we_q, fill_we_d;
    logic [ADDR_W-1:0]     fill_addr_q, fill_addr_d;
    logic [DATA_W-1:0]     fill_data_q, fill_data_d;
    logic                  tag_we_q, tag_we_d;
    logic [ADDR_W-1:0]     tag_addr_q, tag_addr_d;
    logic                  miss;

    assign miss = bus.cache_enable & ~bus.cpu_we & ~bus.lookup_hit;

    always_comb begin
        state_d     = state_q;
        line_base_d = line_base_q;
        count_d     = count_q;
        fill_we_d   = 1'b0;
        fill_addr_d = fill_addr_q;
        fill_data_d = fill_data_q;
        tag_addr_d  = tag_addr_q;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    line_base_d = bus.cpu_addr & LINE_MASK;
                    count_d     = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack) state_d = FILL;
            end
            FILL: begin
                if (bus.mem_rvalid) begin
                    fill_we_d   = 1'b1;
                    fill_addr_d = line_base_q | ADDR_W'(count_q);
                    fill_data_d = bus.mem_rdata;
                    count_d     = count_q + 1'b1;
                    if (count_q == LAST_WORD) begin
                        state_d    = COMMIT;
                        tag_addr_d = line_base_q;
                    end
                end
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status strobes are registered copies of the state being entered.
        mem_req_d = (state_d == REQ);
        busy_n_d  = (state_d == IDLE);
        tag_we_d  = (state_d == COMMIT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            line_base_q <= '0;
            count_q     <= '0;
            busy_n_q    <= 1'b1;
            mem_req_q   <= 1'b0;
            fill_we_q   <= 1'b0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
            tag_we_q    <= 1'b0;
            tag_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            line_base_q <= line_base_d;
            count_q     <= count_d;
            busy_n_q    <= busy_n_d;
            mem_req_q   <= mem_req_d;
            fill_we_q   <= fill_we_d;
            fill_addr_q <= fill_addr_d;
            fill_data_q <= fill_data_d;
            tag_we_q    <= tag_we_d;
            tag_addr_q  <= tag_addr_d;
        end
    end

    assign bus.cache_busy_n = busy_n_q;
    assign bus.mem_req      = mem_req_q;
    assign bus.mem_addr     = line_base_q;
    assign bus.fill_we      = fill_we_q;
    assign bus.fill_addr    = fill_addr_q;
    assign bus.fill_data    = fill_data_q;
    assign bus.tag_we       = tag_we_q;
    assign bus.tag_addr     = tag_addr_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_cache_refill_seq.sv
// Bench for cache_refill_seq: directed and randomized refills checked against a line-level model.
module tb_cache_refill_seq;
    localparam int ADDR_W    = 30;
    localparam int DATA_W    = 32;
    localparam int LINE_LOG2 = 2;
    localparam int WORDS     = 1 << LINE_LOG2;
    localparam int OUT_W     = 3 * ADDR_W + DATA_W + 4;
    localparam logic [ADDR_W-1:0] NOISE_A = ADDR_W'('h2000);
    localparam logic [ADDR_W-1:0] NOISE_B = ADDR_W'('h3000);

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    cache_refill_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    cache_refill_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_LOG2(LINE_LOG2)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        bus.cache_enable = 1'b0;
        bus.cpu_we       = 1'b0;
        bus.lookup_hit   = 1'b0;
        bus.cpu_addr     = ADDR_W'($urandom);
        bus.mem_ack      = 1'b0;
        bus.mem_rvalid   = 1'b0;
        bus.mem_rdata    = $urandom;
    endtask

    function automatic logic [ADDR_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        return (a / ADDR_W'(WORDS)) * ADDR_W'(WORDS);
    endfunction

    function automatic logic [OUT_W-1:0] all_outputs();
        return {bus.cache_busy_n, bus.mem_req, bus.mem_addr, bus.fill_we,
                bus.fill_addr, bus.fill_data, bus.tag_we, bus.tag_addr};
    endfunction

    // One complete refill: miss, ack after ack_delay REQ cycles, rvalid per pat (then all ones).
    task automatic run_refill(input logic [ADDR_W-1:0] addr, input int ack_delay,
                              input logic [15:0] pat, input int pat_len, input bit noise,
                              output int lat);
        logic [ADDR_W-1:0]        base;
        logic [DATA_W-1:0]        d;
        logic [ADDR_W+DATA_W-1:0] want;
        int sent, j, t0;
        bit v;
        lat  = -1;
        base = line_of(addr);
        bus.cache_enable = 1'b1;
        bus.cpu_we       = 1'b0;
        bus.lookup_hit   = 1'b0;
        bus.cpu_addr     = addr;
        tick();
        t0 = cyc;
        bus.cache_enable = 1'b0;
        bus.cpu_addr     = ADDR_W'($urandom);
        checks++;
        if (bus.mem_req !== 1'b1 || bus.cache_busy_n !== 1'b0) begin
            errors++;
            $display("FAIL req_start: mem_req=%b busy_n=%b, want 1 0", bus.mem_req, bus.cache_busy_n);
        end
        checks++;
        if (bus.mem_addr !== base) begin
            errors++;
            $display("FAIL mem_addr: got %h want %h", bus.mem_addr, base);
        end
        for (int k = 0; k < ack_delay; k++) begin
            bus.mem_rvalid = noise;
            bus.mem_rdata  = $urandom;
            tick();
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== base || bus.fill_we !== 1'b0 || bus.cache_busy_n !== 1'b0) begin
                errors++;
                $display("FAIL req_hold: mem_req=%b mem_addr=%h fill_we=%b busy_n=%b, want 1 %h 0 0",
                         bus.mem_req, bus.mem_addr, bus.fill_we, bus.cache_busy_n, base);
            end
        end
        bus.mem_ack    = 1'b1;
        bus.mem_rvalid = noise;
        tick();
        bus.mem_ack    = 1'b0;
        bus.mem_rvalid = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.fill_we !== 1'b0 || bus.cache_busy_n !== 1'b0) begin
            errors++;
            $display("FAIL req_drop: mem_req=%b fill_we=%b busy_n=%b, want 0 0 0",
                     bus.mem_req, bus.fill_we, bus.cache_busy_n);
        end
        sent = 0;
        j    = 0;
        while (sent < WORDS) begin
            v = (j < pat_len) ? pat[j] : 1'b1;
            j++;
            d = $urandom;
            bus.mem_rvalid = v;
            bus.mem_rdata  = d;
            if (noise) begin
                bus.cache_enable = 1'b1;
                bus.lookup_hit   = 1'b0;
                bus.cpu_addr     = (j % 2 == 1) ? NOISE_A : NOISE_B;
            end
            if (v) begin
                exp_q.push_back({base + ADDR_W'(sent), d});
                sent++;
            end
            tick();
            checks++;
            if (bus.fill_we !== v) begin
                errors++;
                $display("FAIL fill_we: got %b want %b (word %0d)", bus.fill_we, v, sent);
            end
            if (bus.fill_we === 1'b1 && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checks++;
                if ({bus.fill_addr, bus.fill_data} !== want) begin
                    errors++;
                    $display("FAIL fill_word: got addr %h data %h want addr %h data %h",
                             bus.fill_addr, bus.fill_data, want[ADDR_W+DATA_W-1:DATA_W], want[DATA_W-1:0]);
                end
            end
            checks++;
            if (bus.tag_we !== (sent == WORDS)) begin
                errors++;
                $display("FAIL tag_we: got %b want %b", bus.tag_we, (sent == WORDS));
            end
            if (sent == WORDS) begin
                lat = cyc - t0;
                checks++;
                if (bus.tag_addr !== base) begin
                    errors++;
                    $display("FAIL tag_addr: got %h want %h", bus.tag_addr, base);
                end
            end
            checks++;
            if (bus.cache_busy_n !== 1'b0) begin
                errors++;
                $display("FAIL busy_fill: got %b want 0", bus.cache_busy_n);
            end
        end
        idle_inputs();
        tick();
        checks++;
        if (bus.cache_busy_n !== 1'b1 || bus.tag_we !== 1'b0 || bus.fill_we !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_return: busy_n=%b tag_we=%b fill_we=%b mem_req=%b, want 1 0 0 0",
                     bus.cache_busy_n, bus.tag_we, bus.fill_we, bus.mem_req);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d words left, want 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [OUT_W-1:0] rst_val;
        rst_val = '0;
        rst_val[OUT_W-1] = 1'b1;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++;
        if (all_outputs() !== rst_val) begin
            errors++;
            $display("FAIL reset_values: got %h want %h", all_outputs(), rst_val);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_no_refill();
        bus.cache_enable = 1'b1;
        bus.cpu_we       = 1'b1;
        bus.lookup_hit   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.cpu_addr = ADDR_W'($urandom);
            tick();
            checks++;
            if (bus.mem_req !== 1'b0 || bus.cache_busy_n !== 1'b1) begin
                errors++;
                $display("FAIL write_miss: mem_req=%b busy_n=%b, want 0 1", bus.mem_req, bus.cache_busy_n);
            end
        end
        bus.cpu_we     = 1'b0;
        bus.lookup_hit = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.cpu_addr = ADDR_W'($urandom);
            tick();
            checks++;
            if (bus.mem_req !== 1'b0 || bus.cache_busy_n !== 1'b1) begin
                errors++;
                $display("FAIL read_hit: mem_req=%b busy_n=%b, want 0 1", bus.mem_req, bus.cache_busy_n);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_basic_miss();
        int lat;
        run_refill(ADDR_W'('h1235), 0, 16'hffff, 0, 1'b0, lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL commit_latency: got T+%0d want T+6", lat + 1);
        end
    endtask

    task automatic test_ack_delay();
        int lat;
        run_refill(ADDR_W'('h0777), 5, 16'h0059, 7, 1'b0, lat);
    endtask

    task automatic test_ignore_during_fill();
        int lat;
        run_refill(ADDR_W'('h1002), 2, 16'h0035, 6, 1'b1, lat);
        tick();
        checks++;
        if (bus.mem_req !== 1'b0 || bus.cache_busy_n !== 1'b1) begin
            errors++;
            $display("FAIL stray_refill: mem_req=%b busy_n=%b, want 0 1", bus.mem_req, bus.cache_busy_n);
        end
    endtask

    task automatic test_reset_mid_refill();
        logic [OUT_W-1:0] rst_val;
        int lat;
        rst_val = '0;
        rst_val[OUT_W-1] = 1'b1;
        bus.cache_enable = 1'b1;
        bus.cpu_addr     = ADDR_W'('h0501);
        tick();
        bus.cache_enable = 1'b0;
        bus.mem_ack      = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = $urandom;
            tick();
            checks++;
            if (bus.fill_we !== 1'b1) begin
                errors++;
                $display("FAIL pre_reset_fill: got %b want 1", bus.fill_we);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (all_outputs() !== rst_val) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", all_outputs(), rst_val);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = $urandom;
            tick();
            checks++;
            if (bus.fill_we !== 1'b0 || bus.tag_we !== 1'b0 || bus.mem_req !== 1'b0 || bus.cache_busy_n !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_idle: fill_we=%b tag_we=%b mem_req=%b busy_n=%b, want 0 0 0 1",
                         bus.fill_we, bus.tag_we, bus.mem_req, bus.cache_busy_n);
            end
        end
        idle_inputs();
        run_refill(ADDR_W'('h0506), 1, 16'h0000, 0, 1'b0, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        run_refill(ADDR_W'('h40), 0, 16'h0000, 0, 1'b0, lat);
        run_refill(ADDR_W'('h80), 1, 16'h000d, 4, 1'b0, lat);
    endtask

    task automatic test_random();
        int lat;
        for (int n = 0; n < 10; n++) begin
            run_refill(ADDR_W'($urandom), $urandom_range(0, 4), 16'($urandom),
                       $urandom_range(0, 10), 1'($urandom_range(0, 1)), lat);
        end
    endtask

    initial begin
        test_reset();
        test_no_refill();
        test_basic_miss();
        test_ack_delay();
        test_ignore_during_fill();
        test_reset_mid_refill();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
